// File: rtl/mult_arbiter_pkg.sv
// Shared multiplier definitions: FSM state encoding and datapath widths.
package mult_arbiter_pkg;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Two-requester multiply bus: request/operand/grant per requester plus result.
interface mult_arbiter_if;
  import mult_arbiter_pkg::*;

  logic              req0;
  logic [OP_W-1:0]   a0;
  logic [OP_W-1:0]   b0;
  logic              gnt0;
  logic              req1;
  logic [OP_W-1:0]   a1;
  logic [OP_W-1:0]   b1;
  logic              gnt1;
  logic [PROD_W-1:0] p_out;
  logic              p_valid;
  logic              p_id;
  logic              busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, p_out, p_valid, p_id, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, p_out, p_valid, p_id, busy
  );

endinterface

// File: rtl/mult_arbiter_multi16.sv
// Multi16: combinational 16x16 unsigned multiplier with full 32-bit product.
module mult_arbiter_multi16
  import mult_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  // Widen before multiplying so no product bits are lost.
  always_comb begin
    p = PROD_W'(a) * PROD_W'(b);
  end

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester arbiter sharing a single Multi16: IDLE -> BUSY -> RESULT.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              p_valid_q, p_valid_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [PROD_W-1:0] p_out_q, p_out_d;
  logic [PROD_W-1:0] prod;
  logic              winner;

  // Single shared multiplier, fed only from the operand registers.
  mult_arbiter_multi16 u_multi16 (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  // Pick the winner: a lone requester always wins; ties use the policy.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = ROUND_ROBIN ? ~last_q : 1'b0;
    end else begin
      winner = bus.req1;
    end
  end

  // Next-state, capture and pulse generation.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    p_out_d   = p_out_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    p_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = BUSY;
          id_d    = winner;
          last_d  = winner;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          op_a_d  = winner ? bus.a1 : bus.a0;
          op_b_d  = winner ? bus.b1 : bus.b0;
        end
      end
      BUSY: begin
        state_d   = RESULT;
        p_out_d   = prod;
        p_valid_d = 1'b1;
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      p_valid_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      p_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      p_valid_q <= p_valid_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      p_out_q   <= p_out_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.p_out   = p_out_q;
  assign bus.p_valid = p_valid_q;
  assign bus.p_id    = id_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances driven in lockstep.
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if ifa ();
  mult_arbiter_if ifb ();

  mult_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(ifa));
  mult_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Index 0: round-robin instance, index 1: fixed-priority instance.
  logic        exp_g  [2][$];
  logic [32:0] exp_p  [2][$];
  int          pv_cyc [2][$];
  int          gcyc   [2];
  logic        pv_prev[2];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input logic id, input logic [31:0] p);
    exp_g[d].push_back(id);
    exp_p[d].push_back({id, p});
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [15:0] x0, input logic [15:0] y0,
                       input logic [15:0] x1, input logic [15:0] y1);
    ifa.req0 = r0; ifa.a0 = x0; ifa.b0 = y0; ifa.req1 = r1; ifa.a1 = x1; ifa.b1 = y1;
    ifb.req0 = r0; ifb.a0 = x0; ifb.b0 = y0; ifb.req1 = r1; ifb.a1 = x1; ifb.b1 = y1;
  endtask

  task automatic mon(input int d, input logic g0, input logic g1, input logic pv,
                     input logic pid, input logic [31:0] po);
    logic        eg;
    logic [32:0] ep;
    chk($sformatf("d%0d_gnt_overlap", d), g0 & g1, 0);
    chk($sformatf("d%0d_pv_double", d), pv_prev[d] & pv, 0);
    if (g0 | g1) begin
      if (exp_g[d].size() == 0) begin
        chk($sformatf("d%0d_unexpected_gnt", d), {g1, g0}, 0);
      end else begin
        eg = exp_g[d].pop_front();
        chk($sformatf("d%0d_gnt_id", d), g1, eg);
      end
      gcyc[d] = cyc;
    end
    if (pv) begin
      if (exp_p[d].size() == 0) begin
        chk($sformatf("d%0d_unexpected_pv", d), pv, 0);
      end else begin
        ep = exp_p[d].pop_front();
        chk($sformatf("d%0d_p_out", d), po, ep[31:0]);
        chk($sformatf("d%0d_p_id", d), pid, ep[32]);
        chk($sformatf("d%0d_latency", d), cyc, gcyc[d] + 1);
      end
      pv_cyc[d].push_back(cyc);
    end
    pv_prev[d] = pv;
  endtask

  // Monitor: samples both instances on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ifa.gnt0, ifa.gnt1, ifa.p_valid, ifa.p_id, ifa.p_out);
      mon(1, ifb.gnt0, ifb.gnt1, ifb.p_valid, ifb.p_id, ifb.p_out);
    end else begin
      pv_prev[0] = 1'b0;
      pv_prev[1] = 1'b0;
    end
  end

  task automatic chk_quiet(input string tag, input logic g0, input logic g1, input logic pv,
                           input logic bsy, input logic pid, input logic [31:0] po,
                           input logic pid_exp, input logic [31:0] po_exp);
    chk({tag, "_gnt"}, {g1, g0}, 0);
    chk({tag, "_p_valid"}, pv, 0);
    chk({tag, "_busy"}, bsy, 0);
    chk({tag, "_p_id"}, pid, pid_exp);
    chk({tag, "_p_out"}, po, po_exp);
  endtask

  task automatic chk_both_quiet(input string tag, input logic pid_exp, input logic [31:0] po_exp);
    chk_quiet({tag, "_rr"}, ifa.gnt0, ifa.gnt1, ifa.p_valid, ifa.busy, ifa.p_id, ifa.p_out, pid_exp, po_exp);
    chk_quiet({tag, "_fp"}, ifb.gnt0, ifb.gnt1, ifb.p_valid, ifb.busy, ifb.p_id, ifb.p_out, pid_exp, po_exp);
  endtask

  task automatic chk_gaps(input int d, input int n);
    chk($sformatf("d%0d_pv_count", d), pv_cyc[d].size(), n);
    for (int i = 1; i < pv_cyc[d].size(); i++) begin
      chk($sformatf("d%0d_pv_gap", d), pv_cyc[d][i] - pv_cyc[d][i-1], 3);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_both_quiet("reset", 1'b0, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    pv_prev[0] = 1'b0; pv_prev[1] = 1'b0;
    gcyc[0] = 0; gcyc[1] = 0;

    // Single op granted on the first edge after reset; a req1 pulse during BUSY is ignored.
    do_reset();
    drive(1, 0, 16'd122, 16'd122, 0, 0);
    push(0, 1'b0, 32'd14884); push(1, 1'b0, 32'd14884);
    @(posedge clk); #1 drive(0, 1, 0, 0, 16'd9, 16'd9);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_both_quiet("hold1", 1'b0, 32'd14884);

    // Requester 1 held high: 15*1 then 10*10, three cycles apart.
    pv_cyc[0].delete(); pv_cyc[1].delete();
    @(posedge clk); #1 drive(0, 1, 0, 0, 16'd15, 16'd1);
    push(0, 1'b1, 32'd15); push(1, 1'b1, 32'd15);
    @(posedge clk); #1 drive(0, 1, 0, 0, 16'd10, 16'd10);
    push(0, 1'b1, 32'd100); push(1, 1'b1, 32'd100);
    repeat (3) @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_gaps(0, 2); chk_gaps(1, 2);
    chk_both_quiet("hold2", 1'b1, 32'd100);

    // Tie after reset: round-robin alternates 0,1,0; fixed priority always 0.
    do_reset();
    pv_cyc[0].delete(); pv_cyc[1].delete();
    drive(1, 1, 16'd2, 16'd3, 16'd4, 16'd5);
    push(0, 1'b0, 32'd6); push(0, 1'b1, 32'd20); push(0, 1'b0, 32'd6);
    push(1, 1'b0, 32'd6); push(1, 1'b0, 32'd6); push(1, 1'b0, 32'd6);
    repeat (7) @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_gaps(0, 3); chk_gaps(1, 3);

    // Largest operands: full 32-bit product.
    @(posedge clk); #1 drive(1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    push(0, 1'b0, 32'hFFFE0001); push(1, 1'b0, 32'hFFFE0001);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_both_quiet("hold_max", 1'b0, 32'hFFFE0001);

    // Reset during BUSY aborts the op; a later request completes normally.
    @(posedge clk); #1 drive(1, 0, 16'd7, 16'd9, 0, 0);
    exp_g[0].push_back(1'b0); exp_g[1].push_back(1'b0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_both_quiet("abort", 1'b0, 32'h0);
    drive(1, 0, 16'd5, 16'd6, 0, 0);
    push(0, 1'b0, 32'd30); push(1, 1'b0, 32'd30);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rr_pending", exp_g[0].size() + exp_p[0].size(), 0);
    chk("fp_pending", exp_g[1].size() + exp_p[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request, level.
REQ-005 a0, b0  input  16 each  requester 0 unsigned operands; valid while req0 is high.
REQ-006 gnt0  output  1  one-cycle pulse; requester 0 operands captured.
REQ-007 req1, a1, b1, gnt1  as REQ-004..006, for requester 1.
REQ-008 p_out  output  32  registered unsigned product.
REQ-009 p_valid  output  1  one-cycle pulse; p_out and p_id are valid.
REQ-010 p_id  output  1  requester that owns the current p_out (0/1).
REQ-011 busy  output  1  high in states BUSY and RESULT.

Function
REQ-012 The block shall contain exactly one Multi16 instance, shared by both requesters.
REQ-013 FSM states: IDLE, BUSY, RESULT.
REQ-014 FSM transitions: IDLE->BUSY on an edge where req0|req1 is sampled high; BUSY->RESULT unconditionally; RESULT->IDLE unconditionally.
REQ-015 On the IDLE->BUSY edge, the block shall latch the winner's a/b into operand registers, latch the winner index into the id register, and assert the winner's gnt for exactly the following cycle.
REQ-016 Multi16 inputs shall come only from the operand registers, never directly from a0/b0/a1/b1.
REQ-017 On the BUSY->RESULT edge, p_out shall load the Multi16 product, and p_valid shall be 1 for exactly the RESULT cycle.
REQ-018 Latency: with req sampled at edge E0, gnt is high in E0..E1, p_valid is high in E1..E2, and the next grant can occur no earlier than E3 (one operation per 3 cycles).
REQ-019 req sampled in BUSY or RESULT shall be ignored, with no queueing beyond the level of req itself.
REQ-020 A requester whose req stays high after its gnt shall be treated as issuing a new request.
REQ-021 Arbitration with both req high in IDLE:
  - ROUND_ROBIN=1: grant the requester not granted last.
  - ROUND_ROBIN=0: grant requester 0.
REQ-022 The last-grant pointer shall update only on a grant.
REQ-023 When only one req is high, that requester shall be granted regardless of the pointer.
REQ-024 gnt0 and gnt1 shall never be high in the same cycle.
REQ-025 p_out shall hold its value after p_valid falls until the next RESULT.
REQ-026 The product shall be the full 32-bit unsigned result with no truncation; the maximum is 0xFFFF*0xFFFF = 0xFFFE0001.
REQ-027 A req dropped before it is granted shall leave no effect.

Reset
REQ-028 While rst=1, the block shall drive: state=IDLE, gnt0=gnt1=0, p_valid=0, p_out=0, p_id=0, busy=0, operand regs=0, last-grant pointer=1 (requester 0 wins the first tie).
REQ-029 rst asserted in BUSY or RESULT shall abort the operation: no p_valid, p_out=0 on the next cycle.
REQ-030 rst has priority over every other event on the same edge, including a pending req.
REQ-031 The first grant after rst deasserts shall be possible on the first edge with rst=0.

Structure
REQ-032 FSM state encodings (IDLE=0, BUSY=1, RESULT=2) and operand/product widths (16, 32) shall live in the shared multiplier package/include file, which Multi16 benches also use.
REQ-033 Multi16 is the only sub-module, used unmodified; arbitration logic shall stay inline in mult_arbiter.

Verification
REQ-034 The bench shall apply these directed scenarios:
  - Single op: req0, a0=122, b0=122 -> gnt0 at E0, p_valid at E1, p_out=14884 (0x3A24), p_id=0.
  - Sequential ops: req1 with 15*1, then req1 with 10*10 -> p_out=15 then 100, p_id=1, p_valid pulses 3 cycles apart.
  - Tie after reset, ROUND_ROBIN=1: req0 and req1 held high (a0=2,b0=3; a1=4,b1=5) -> grants alternate 0,1,0; p_out 6,20,6.
  - Tie, ROUND_ROBIN=0: same stimulus -> gnt0 only, p_out=6 every 3 cycles.
  - Max operands: 0xFFFF*0xFFFF -> p_out=0xFFFE0001.
  - Reset mid-op: rst pulsed in the BUSY cycle -> no p_valid, p_out=0, busy=0; a req0 made after reset completes normally.
REQ-035 In every scenario, the bench shall assert that gnt0&gnt1 is never 1 and that p_valid is never high for 2 consecutive cycles.
